// File: rtl/i2c_slave_rx.sv
// I2C slave receiver: oversampled SCL/SDA, START/STOP detection, LSB-first
// address + data reception, open-drain ACK and one-cycle data strobe.
module i2c_slave_rx #(
    parameter logic [7:0]  SLAVE_ADDR  = 8'h5A,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] Data_out,
    output logic       Data_valid,
    output logic       Addr_match,
    output logic       Busy,
    output logic       Stop_det
);

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned SYNC_TOP = SYNC_STAGES - 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_DATA_ACK = 3'd4;
    localparam logic [2:0] ST_IGNORE   = 3'd5;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_hist_q, scl_hist_d;
    logic                   sda_hist_q, sda_hist_d;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] sr_q, sr_d;
    logic              sda_oe_q, sda_oe_d;
    logic [BYTE_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              addr_match_q, addr_match_d;
    logic              busy_q, busy_d;
    logic              stop_det_q, stop_det_d;

    logic              s_scl_c, s_sda_c, p_scl_c, p_sda_c;
    logic              scl_rise_c, scl_fall_c, start_c, stop_c;
    logic              last_bit_c;
    logic [BYTE_W-1:0] sr_next_c;

    // Synchronizer chains and one-deep history for edge/condition detection
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], SCL};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], SDA};
        scl_hist_d = scl_sync_q[SYNC_TOP];
        sda_hist_d = sda_sync_q[SYNC_TOP];
    end

    // Bus events derived only from synchronized samples
    always_comb begin
        s_scl_c    = scl_sync_q[SYNC_TOP];
        s_sda_c    = sda_sync_q[SYNC_TOP];
        p_scl_c    = scl_hist_q;
        p_sda_c    = sda_hist_q;
        scl_rise_c = !p_scl_c && s_scl_c;
        scl_fall_c = p_scl_c && !s_scl_c;
        start_c    = p_scl_c && s_scl_c && p_sda_c && !s_sda_c;
        stop_c     = p_scl_c && s_scl_c && !p_sda_c && s_sda_c;
        sr_next_c  = {s_sda_c, sr_q[BYTE_W-1:1]};
        last_bit_c = (cnt_q == CNT_W'(7));
    end

    // Next-state and output logic; START/STOP override any SCL edge
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        sda_oe_d     = sda_oe_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        addr_match_d = addr_match_q;
        stop_det_d   = 1'b0;

        if (stop_c) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            stop_det_d   = 1'b1;
            addr_match_d = 1'b0;
            sda_oe_d     = 1'b0;
        end else if (start_c) begin
            state_d      = ST_ADDR;
            cnt_d        = '0;
            addr_match_d = 1'b0;
            sda_oe_d     = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise_c) begin
                        sr_d = sr_next_c;
                        if (last_bit_c) begin
                            cnt_d = '0;
                            if (sr_next_c == SLAVE_ADDR) begin
                                state_d      = ST_ADDR_ACK;
                                addr_match_d = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (scl_rise_c) begin
                        sr_d = sr_next_c;
                        if (last_bit_c) begin
                            cnt_d        = '0;
                            data_out_d   = sr_next_c;
                            data_valid_d = 1'b1;
                            state_d      = ST_DATA_ACK;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    // First fall (end of bit 8) pulls SDA; second fall (end of bit 9) releases
                    if (scl_fall_c) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = ST_DATA;
                        end
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State registers; synchronizers reset to idle-bus level
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_hist_q   <= 1'b1;
            sda_hist_q   <= 1'b1;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sr_q         <= '0;
            sda_oe_q     <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
            stop_det_q   <= 1'b0;
        end else begin
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_hist_q   <= scl_hist_d;
            sda_hist_q   <= sda_hist_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            sda_oe_q     <= sda_oe_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            addr_match_q <= addr_match_d;
            busy_q       <= busy_d;
            stop_det_q   <= stop_det_d;
        end
    end

    // Open-drain SDA: drive low or float
    assign SDA = sda_oe_q ? 1'b0 : 1'bz;

    assign Data_out   = data_out_q;
    assign Data_valid = data_valid_q;
    assign Addr_match = addr_match_q;
    assign Busy       = busy_q;
    assign Stop_det   = stop_det_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: directed I2C master stimulus with a data-byte scoreboard.
module tb_i2c_slave_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m_low = 1'b0;
    wire        sda_bus;
    logic [7:0] Data_out;
    logic       Data_valid, Addr_match, Busy, Stop_det;

    assign sda_bus = sda_m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave_rx #(.SLAVE_ADDR(8'h5A), .SYNC_STAGES(2)) dut (
        .CLK(clk), .RST_n(rst_n), .SCL(scl), .SDA(sda_bus),
        .Data_out(Data_out), .Data_valid(Data_valid), .Addr_match(Addr_match),
        .Busy(Busy), .Stop_det(Stop_det)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int stop_cnt = 0;
    int exp_stops = 0;
    int pull_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m_low = 1'b1; wclk(4);
        scl = 1'b0;       wclk(2);
    endtask

    task automatic i2c_rstart();
        sda_m_low = 1'b0; wclk(4);
        scl = 1'b1;       wclk(4);
        i2c_start();
    endtask

    task automatic i2c_stop();
        scl = 1'b0;       wclk(2);
        sda_m_low = 1'b1; wclk(4);
        scl = 1'b1;       wclk(4);
        sda_m_low = 1'b0; wclk(4);
        exp_stops++;
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        if (glitch) begin
            sda_m_low = 1'b1; wclk(1);
            sda_m_low = 1'b0; wclk(1);
            sda_m_low = 1'b1; wclk(1);
            sda_m_low = 1'b0; wclk(1);
        end
        sda_m_low = !b; wclk(4);
        scl = 1'b1;     wclk(4);
        scl = 1'b0;     wclk(2);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    endtask

    // Ninth clock: master releases SDA and samples it mid-high
    task automatic ack_clock(input logic exp_ack, input string nm);
        sda_m_low = 1'b0; wclk(4);
        scl = 1'b1;       wclk(2);
        check(nm, 32'(sda_bus), exp_ack ? 32'd0 : 32'd1);
        wclk(2);
        scl = 1'b0;       wclk(2);
    endtask

    // Monitor: scoreboard on Data_valid, STOP pulse count, slave pull-down count
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk); #1;
            if (rst_n) begin
                if (Data_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_valid actual=0x%0h expected=none at %0t", Data_out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_data_out", 32'(Data_out), 32'(e));
                    end
                end
                if (Stop_det) stop_cnt++;
                if (!sda_m_low && sda_bus == 1'b0) pull_cnt++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, p0;
        wclk(5);
        check("rst_data_out", 32'(Data_out), 32'h0);
        check("rst_valid", 32'(Data_valid), 32'h0);
        check("rst_match", 32'(Addr_match), 32'h0);
        check("rst_busy", 32'(Busy), 32'h0);
        check("rst_stop", 32'(Stop_det), 32'h0);
        check("rst_sda", 32'(sda_bus), 32'h1);
        rst_n = 1'b1; wclk(4);

        // Reset asserted while the slave holds the address ACK
        i2c_start();
        send_byte(8'h5A, 1'b0);
        sda_m_low = 1'b0; wclk(4);
        scl = 1'b1; wclk(2);
        check("pre_rst_ack_sda", 32'(sda_bus), 32'h0);
        check("pre_rst_match", 32'(Addr_match), 32'h1);
        rst_n = 1'b0; #1;
        check("midack_rst_sda", 32'(sda_bus), 32'h1);
        check("midack_rst_match", 32'(Addr_match), 32'h0);
        check("midack_rst_busy", 32'(Busy), 32'h0);
        check("midack_rst_data", 32'(Data_out), 32'h0);
        wclk(4);
        rst_n = 1'b1; wclk(4);

        // Matching single-byte write
        exp_q.push_back(8'hC3);
        i2c_start();
        send_byte(8'h5A, 1'b0);
        ack_clock(1'b1, "m_addr_ack");
        check("m_match", 32'(Addr_match), 32'h1);
        check("m_busy", 32'(Busy), 32'h1);
        send_byte(8'hC3, 1'b0);
        ack_clock(1'b1, "m_data_ack");
        s0 = stop_cnt;
        i2c_stop();
        check("m_stop_pulse", 32'(stop_cnt - s0), 32'd1);
        check("m_busy_after", 32'(Busy), 32'h0);
        check("m_match_after", 32'(Addr_match), 32'h0);
        check("m_data_out", 32'(Data_out), 32'hC3);
        check("m_sb_empty", 32'(exp_q.size()), 32'd0);

        // Address mismatch: slave stays silent
        p0 = pull_cnt;
        i2c_start();
        send_byte(8'h5B, 1'b0);
        ack_clock(1'b0, "x_addr_nack");
        check("x_match", 32'(Addr_match), 32'h0);
        check("x_busy_ignore", 32'(Busy), 32'h1);
        send_byte(8'hFF, 1'b0);
        ack_clock(1'b0, "x_data_nack");
        i2c_stop();
        check("x_busy_after", 32'(Busy), 32'h0);
        check("x_no_pull", 32'(pull_cnt - p0), 32'd0);
        check("x_data_hold", 32'(Data_out), 32'hC3);

        // Three-byte burst
        exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'hAA);
        i2c_start();
        send_byte(8'h5A, 1'b0);
        ack_clock(1'b1, "b_addr_ack");
        send_byte(8'h01, 1'b0); ack_clock(1'b1, "b_ack0");
        send_byte(8'h80, 1'b0); ack_clock(1'b1, "b_ack1");
        send_byte(8'hAA, 1'b0); ack_clock(1'b1, "b_ack2");
        i2c_stop();
        check("b_data_out", 32'(Data_out), 32'hAA);
        check("b_sb_empty", 32'(exp_q.size()), 32'd0);

        // Repeated START after a partial data byte
        i2c_start();
        send_byte(8'h5A, 1'b0);
        ack_clock(1'b1, "r_addr_ack1");
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0);
        i2c_rstart();
        check("r_match_cleared", 32'(Addr_match), 32'h0);
        check("r_busy", 32'(Busy), 32'h1);
        exp_q.push_back(8'h3C);
        send_byte(8'h5A, 1'b0);
        ack_clock(1'b1, "r_addr_ack2");
        send_byte(8'h3C, 1'b0);
        ack_clock(1'b1, "r_data_ack");
        i2c_stop();
        check("r_data_out", 32'(Data_out), 32'h3C);
        check("r_sb_empty", 32'(exp_q.size()), 32'd0);

        // STOP after five address bits
        s0 = stop_cnt; p0 = pull_cnt;
        i2c_start();
        for (int i = 0; i < 5; i++) send_bit(1'(i % 2), 1'b0);
        i2c_stop();
        check("a_stop_pulse", 32'(stop_cnt - s0), 32'd1);
        check("a_busy", 32'(Busy), 32'h0);
        check("a_no_ack", 32'(pull_cnt - p0), 32'd0);
        check("a_data_hold", 32'(Data_out), 32'h3C);

        // STOP while idle
        s0 = stop_cnt;
        i2c_stop();
        check("i_stop_pulse", 32'(stop_cnt - s0), 32'd1);
        check("i_busy", 32'(Busy), 32'h0);

        // SDA chatter while SCL low inside a data byte
        exp_q.push_back(8'h96);
        s0 = stop_cnt;
        i2c_start();
        send_byte(8'h5A, 1'b0);
        ack_clock(1'b1, "g_addr_ack");
        send_byte(8'h96, 1'b1);
        check("g_busy_mid", 32'(Busy), 32'h1);
        check("g_match_mid", 32'(Addr_match), 32'h1);
        ack_clock(1'b1, "g_data_ack");
        i2c_stop();
        check("g_stop_once", 32'(stop_cnt - s0), 32'd1);
        check("g_data_out", 32'(Data_out), 32'h96);
        check("g_sb_empty", 32'(exp_q.size()), 32'd0);

        wclk(4);
        check("total_stops", 32'(stop_cnt), 32'(exp_stops));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
